// File: rtl/thumb_encode_imm.sv
// Multi-cycle search for the Thumb modified-immediate (imm12) encoding of a 32-bit constant.
// The four replicated-byte forms are tested in one cycle, then rotations 8..31 are walked one per cycle.
module thumb_encode_imm (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic [11:0] imm12
);

  localparam int unsigned VW  = 32;
  localparam int unsigned RW  = 5;
  localparam int unsigned IW  = 12;
  localparam logic [RW-1:0] ROT_FIRST = RW'(8);
  localparam logic [RW-1:0] ROT_LAST  = RW'(31);

  typedef enum logic [1:0] {IDLE, PAT, SEARCH, DONE} state_t;

  state_t        state, next_state;
  logic [VW-1:0] v, v_d;
  logic [RW-1:0] rot, rot_d;
  logic          ok_d, busy_d, done_d;
  logic [IW-1:0] imm_d;

  logic [7:0]    b, bh;
  logic          pat_hit;
  logic [IW-1:0] pat_imm;
  logic [VW-1:0] r;
  logic          srch_hit;

  // Replicated-byte forms, checked in priority order so v=0 lands on the plain-byte form.
  always_comb begin
    b       = v[7:0];
    bh      = v[15:8];
    pat_hit = 1'b1;
    pat_imm = '0;
    if (v[31:8] == 24'h0)
      pat_imm = {4'b0000, b};
    else if (v == {8'h00, b, 8'h00, b} && b != 8'h00)
      pat_imm = {4'b0001, b};
    else if (v == {bh, 8'h00, bh, 8'h00} && bh != 8'h00)
      pat_imm = {4'b0010, bh};
    else if (v == {b, b, b, b} && b != 8'h00)
      pat_imm = {4'b0011, b};
    else
      pat_hit = 1'b0;
  end

  // Rotate left by rot; the right-shift amount wraps to 0 when rot is 0, giving v|v.
  always_comb begin
    r        = (v << rot) | (v >> RW'(RW'(0) - rot));
    srch_hit = (r[31:8] == 24'h0) && r[7];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = PAT;
      PAT:     next_state = pat_hit ? DONE : SEARCH;
      SEARCH:  if (srch_hit || rot == ROT_LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    v_d    = v;
    rot_d  = rot;
    ok_d   = ok;
    imm_d  = imm12;
    busy_d = (next_state != IDLE);
    done_d = (next_state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          v_d   = value;
          ok_d  = 1'b0;
          imm_d = '0;
        end
      end
      PAT: begin
        if (pat_hit) begin
          ok_d  = 1'b1;
          imm_d = pat_imm;
        end else begin
          rot_d = ROT_FIRST;
        end
      end
      SEARCH: begin
        if (srch_hit) begin
          ok_d  = 1'b1;
          imm_d = {rot, r[6:0]};
        end else if (rot == ROT_LAST) begin
          ok_d  = 1'b0;
          imm_d = '0;
        end else begin
          rot_d = RW'(rot + RW'(1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v     <= '0;
      rot   <= '0;
      ok    <= 1'b0;
      imm12 <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      v     <= v_d;
      rot   <= rot_d;
      ok    <= ok_d;
      imm12 <= imm_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

endmodule
